// File: rtl/cabac_rate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cabac_rate_pkg
// Brief    : Shared types, init cost tables and clamp helper for the CABAC
//            context bit-cost table.
// Revision : 1.0 - initial release
// ============================================================================
package cabac_rate_pkg;

  localparam int COST_W_PKG   = 16;
  localparam int N_CTX_TYPES  = 2;
  localparam int N_TABLE_CTX  = 8;

  typedef logic [COST_W_PKG-1:0] cost_t;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // [type][ctx][bin]; contexts beyond the table depth reuse entries modulo 8
  localparam cost_t CTX_INIT_COST [N_CTX_TYPES][N_TABLE_CTX][2] = '{
    '{ '{16'h0100, 16'h0380}, '{16'h0200, 16'h0290}, '{16'h0150, 16'h0410},
       '{16'h0090, 16'h05A0}, '{16'h0300, 16'h0180}, '{16'h0220, 16'h0240},
       '{16'h0400, 16'h0110}, '{16'h0170, 16'h0330} },
    '{ '{16'h0080, 16'h0500}, '{16'h0120, 16'h0310}, '{16'h0260, 16'h0260},
       '{16'h0340, 16'h00C0}, '{16'h0050, 16'h0600}, '{16'h01A0, 16'h02E0},
       '{16'h02B0, 16'h01D0}, '{16'h0010, 16'h0700} }
  };

  function automatic cost_t sat_add_cost(input cost_t cost, input cost_t delta);
    logic signed [COST_W_PKG+1:0] sum;
    sum = $signed({2'b00, cost}) + $signed({{2{delta[COST_W_PKG-1]}}, delta});
    if (sum < 0)
      return '0;
    else if (sum > $signed({2'b00, {COST_W_PKG{1'b1}}}))
      return '1;
    else
      return sum[COST_W_PKG-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/context_cost_init_rom.sv
`default_nettype none
// ============================================================================
// Module   : context_cost_init_rom
// Brief    : Combinational lookup of both bin init costs for one context.
// Revision : 1.0 - initial release
// ============================================================================
module context_cost_init_rom
  import cabac_rate_pkg::*;
#(
  parameter int CTX_TYPE = 0,
  parameter int IDX_W    = 3
) (
  input  logic [IDX_W-1:0] idx,
  output cost_t            init0,
  output cost_t            init1
);

  logic [2:0] w_row;

  assign w_row = 3'(idx);
  assign init0 = CTX_INIT_COST[CTX_TYPE][w_row][0];
  assign init1 = CTX_INIT_COST[CTX_TYPE][w_row][1];

endmodule
`default_nettype wire

// File: rtl/context_cost_table.sv
`default_nettype none
// ============================================================================
// Module   : context_cost_table
// Brief    : Per-context two-bin bit-cost store with self-init sequencer,
//            overwrite/saturating-accumulate writes and NUM_RD read channels.
// Revision : 1.0 - initial release
// ============================================================================
module context_cost_table
  import cabac_rate_pkg::*;
#(
  parameter int NUM_CTX  = 8,
  parameter int CTX_TYPE = 0,
  parameter int COST_W   = 16,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_req,
  output logic                     ready,
  input  logic                     wr_en,
  input  logic                     wr_mode,
  input  logic [ADDR_W-1:0]        wr_ctx,
  input  logic                     wr_bin,
  input  logic [COST_W-1:0]        wr_data,
  output logic                     wr_drop,
  input  logic [NUM_RD*ADDR_W-1:0] rd_ctx,
  input  logic [NUM_RD-1:0]        rd_bin,
  output logic [NUM_RD*COST_W-1:0] rd_cost,
  output logic [NUM_RD*COST_W-1:0] rd_cost0,
  output logic [NUM_RD*COST_W-1:0] rd_cost1
);

  localparam int              c_IDX_W    = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam logic [ADDR_W:0] c_NUM_CTX  = (ADDR_W+1)'(NUM_CTX);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_CTX - 1);

  state_t             r_state, w_state_nxt;
  logic [c_IDX_W-1:0] r_idx, w_idx_nxt;
  logic               r_wr_drop;
  cost_t              r_cost0 [NUM_CTX];
  cost_t              r_cost1 [NUM_CTX];

  cost_t              w_init0, w_init1;
  logic               w_wr_ok;
  logic [c_IDX_W-1:0] w_wr_idx;
  cost_t              w_wr_cur, w_wr_val;

  context_cost_init_rom #(
    .CTX_TYPE (CTX_TYPE),
    .IDX_W    (c_IDX_W)
  ) u_init_rom (
    .idx   (r_idx),
    .init0 (w_init0),
    .init1 (w_init1)
  );

  assign ready   = (r_state == READY);
  assign wr_drop = r_wr_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      INIT: begin
        if (init_req) begin
          w_idx_nxt = '0;
        end else if (r_idx == c_LAST_IDX) begin
          w_state_nxt = READY;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + c_IDX_W'(1);
        end
      end
      READY: begin
        if (init_req) begin
          w_state_nxt = INIT;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Write datapath; the computed value also feeds the read bypass
  assign w_wr_ok  = ready && wr_en && ({1'b0, wr_ctx} < c_NUM_CTX);
  assign w_wr_idx = wr_ctx[c_IDX_W-1:0];
  assign w_wr_cur = wr_bin ? r_cost1[w_wr_idx] : r_cost0[w_wr_idx];
  assign w_wr_val = wr_mode ? sat_add_cost(w_wr_cur, cost_t'(wr_data)) : cost_t'(wr_data);

  always_ff @(posedge clk) begin
    if (rst)
      r_wr_drop <= 1'b0;
    else
      r_wr_drop <= wr_en && !w_wr_ok;
  end

  // Storage has no reset; the sequencer fills it before ready rises
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_cost0[r_idx] <= w_init0;
      r_cost1[r_idx] <= w_init1;
    end else if (w_wr_ok) begin
      if (wr_bin)
        r_cost1[w_wr_idx] <= w_wr_val;
      else
        r_cost0[w_wr_idx] <= w_wr_val;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0]  w_ctx;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_ok, w_hit;
    cost_t              w_b0, w_b1;
    cost_t              r_c, r_c0, r_c1;

    assign w_ctx = rd_ctx[k*ADDR_W +: ADDR_W];
    assign w_idx = w_ctx[c_IDX_W-1:0];
    assign w_ok  = ready && ({1'b0, w_ctx} < c_NUM_CTX);
    assign w_hit = w_wr_ok && (w_ctx == wr_ctx);
    assign w_b0  = (w_hit && !wr_bin) ? w_wr_val : r_cost0[w_idx];
    assign w_b1  = (w_hit &&  wr_bin) ? w_wr_val : r_cost1[w_idx];

    always_ff @(posedge clk) begin
      if (rst || !w_ok) begin
        r_c  <= '0;
        r_c0 <= '0;
        r_c1 <= '0;
      end else begin
        r_c  <= rd_bin[k] ? w_b1 : w_b0;
        r_c0 <= w_b0;
        r_c1 <= w_b1;
      end
    end

    assign rd_cost [k*COST_W +: COST_W] = r_c;
    assign rd_cost0[k*COST_W +: COST_W] = r_c0;
    assign rd_cost1[k*COST_W +: COST_W] = r_c1;
  end

endmodule
`default_nettype wire

// File: tb/tb_context_cost_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_context_cost_table
// Brief    : Self-checking bench with a behavioural table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_context_cost_table;

  localparam int NUM_CTX = 8;
  localparam int NUM_RD  = 2;
  localparam int COST_W  = 16;
  localparam int ADDR_W  = 8;

  logic                     clk = 1'b0;
  logic                     rst, init_req, ready;
  logic                     wr_en, wr_mode, wr_bin, wr_drop;
  logic [ADDR_W-1:0]        wr_ctx;
  logic [COST_W-1:0]        wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_ctx;
  logic [NUM_RD-1:0]        rd_bin;
  logic [NUM_RD*COST_W-1:0] rd_cost, rd_cost0, rd_cost1;

  always #5 clk = ~clk;

  context_cost_table #(
    .NUM_CTX (NUM_CTX), .CTX_TYPE (0), .COST_W (COST_W),
    .NUM_RD (NUM_RD), .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk), .rst (rst), .init_req (init_req), .ready (ready),
    .wr_en (wr_en), .wr_mode (wr_mode), .wr_ctx (wr_ctx), .wr_bin (wr_bin),
    .wr_data (wr_data), .wr_drop (wr_drop),
    .rd_ctx (rd_ctx), .rd_bin (rd_bin),
    .rd_cost (rd_cost), .rd_cost0 (rd_cost0), .rd_cost1 (rd_cost1)
  );

  int checks = 0;
  int errors = 0;

  // Independent copy of the type-0 init costs
  int init_tab [8][2] = '{
    '{'h0100, 'h0380}, '{'h0200, 'h0290}, '{'h0150, 'h0410}, '{'h0090, 'h05A0},
    '{'h0300, 'h0180}, '{'h0220, 'h0240}, '{'h0400, 'h0110}, '{'h0170, 'h0330}
  };

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: table contents, init progress and expected outputs
  int   m_cost [NUM_CTX][2];
  bit   m_ready = 1'b0;
  int   m_cnt   = 0;
  bit   e_ready, e_drop;
  int   e_c [NUM_RD], e_c0 [NUM_RD], e_c1 [NUM_RD];

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      e_drop  = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
        e_c[k] = 0; e_c0[k] = 0; e_c1[k] = 0;
      end
    end else begin
      bit acc;
      acc    = m_ready && wr_en && (int'(wr_ctx) < NUM_CTX);
      e_drop = wr_en && !acc;
      if (acc) begin
        if (wr_mode) begin
          int v;
          v = m_cost[wr_ctx][wr_bin] + int'($signed(wr_data));
          if (v < 0) v = 0;
          if (v > 65535) v = 65535;
          m_cost[wr_ctx][wr_bin] = v;
        end else begin
          m_cost[wr_ctx][wr_bin] = int'(wr_data);
        end
      end
      for (int k = 0; k < NUM_RD; k++) begin
        int c;
        c = int'(rd_ctx[k*ADDR_W +: ADDR_W]);
        if (m_ready && c < NUM_CTX) begin
          e_c0[k] = m_cost[c][0];
          e_c1[k] = m_cost[c][1];
          e_c[k]  = rd_bin[k] ? m_cost[c][1] : m_cost[c][0];
        end else begin
          e_c[k] = 0; e_c0[k] = 0; e_c1[k] = 0;
        end
      end
      if (m_ready) begin
        if (init_req) begin
          m_ready = 1'b0;
          m_cnt   = 0;
        end
      end else if (init_req) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt == NUM_CTX) begin
          m_ready = 1'b1;
          for (int i = 0; i < NUM_CTX; i++) begin
            m_cost[i][0] = init_tab[i % 8][0];
            m_cost[i][1] = init_tab[i % 8][1];
          end
        end
      end
    end
    e_ready = m_ready;
    #1;
    chk("ready", 32'(ready), 32'(e_ready));
    chk("wr_drop", 32'(wr_drop), 32'(e_drop));
    for (int k = 0; k < NUM_RD; k++) begin
      chk($sformatf("rd_cost[%0d]", k),  32'(rd_cost[k*COST_W +: COST_W]),  32'(e_c[k]));
      chk($sformatf("rd_cost0[%0d]", k), 32'(rd_cost0[k*COST_W +: COST_W]), 32'(e_c0[k]));
      chk($sformatf("rd_cost1[%0d]", k), 32'(rd_cost1[k*COST_W +: COST_W]), 32'(e_c1[k]));
    end
  end

  task automatic idle();
    rst = 0; init_req = 0; wr_en = 0; wr_mode = 0; wr_ctx = '0; wr_bin = 0;
    wr_data = '0; rd_ctx = '0; rd_bin = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input bit mode, input int ctx, input bit bin, input int data);
    wr_en = 1; wr_mode = mode; wr_ctx = 8'(ctx); wr_bin = bin; wr_data = 16'(data);
  endtask

  task automatic rd(input int ch, input int ctx, input bit bin);
    rd_ctx[ch*ADDR_W +: ADDR_W] = 8'(ctx);
    rd_bin[ch] = bin;
  endtask

  initial begin
    idle();
    rst = 1;
    cyc(2);
    rst = 0;
    wr(0, 1, 0, 'h1111);
    cyc(1);
    idle();
    chk("drop_during_init", 32'(wr_drop), 32'd1);
    cyc(6);
    chk("ready_low_7", 32'(ready), 32'd0);
    cyc(1);
    chk("ready_up_8", 32'(ready), 32'd1);

    rd(0, 2, 1); rd(1, 7, 0);
    cyc(1);
    chk("init_ctx2_b1", 32'(rd_cost[15:0]), 32'h0410);
    chk("init_ctx7_b0", 32'(rd_cost[31:16]), 32'h0170);

    idle();
    wr(0, 100, 0, 'hDEAD); rd(0, 31, 1);
    cyc(1);
    chk("drop_ctx100", 32'(wr_drop), 32'd1);
    chk("rd_ctx31_zero", 32'(rd_cost0[15:0]), 32'd0);
    idle();
    for (int i = 0; i < NUM_CTX; i++) begin
      rd(0, i, i[0]); rd(1, i, !i[0]);
      cyc(1);
    end

    idle();
    wr(0, 1, 0, 'h1111); cyc(1);
    wr(0, 1, 1, 'h2222); cyc(1);
    wr(0, 4, 0, 'hAAAA); rd(0, 1, 0); rd(1, 1, 1); cyc(1);
    chk("ctx1_b0", 32'(rd_cost[15:0]), 32'h1111);
    chk("ctx1_b1", 32'(rd_cost[31:16]), 32'h2222);
    idle();
    rd(0, 4, 0); cyc(1);
    chk("ctx4_b0", 32'(rd_cost0[15:0]), 32'hAAAA);
    chk("ctx4_b1", 32'(rd_cost1[15:0]), 32'h0180);

    idle();
    wr(0, 5, 1, 'hFACE); rd(0, 5, 1); rd(1, 5, 1); cyc(1);
    chk("bypass_ch0", 32'(rd_cost[15:0]), 32'hFACE);
    chk("bypass_ch1", 32'(rd_cost[31:16]), 32'hFACE);

    idle();
    wr(0, 3, 0, 'hFFF0); cyc(1);
    wr(1, 3, 0, 'h0020); cyc(1);
    idle(); rd(0, 3, 0); cyc(1);
    chk("sat_high", 32'(rd_cost[15:0]), 32'hFFFF);
    chk("sat_high_b1", 32'(rd_cost1[15:0]), 32'h05A0);
    wr(0, 3, 0, 'h0100); cyc(1);
    wr(1, 3, 0, 'h8000); cyc(1);
    chk("sat_low_bypass", 32'(rd_cost[15:0]), 32'h0000);
    chk("sat_low_b1", 32'(rd_cost1[15:0]), 32'h05A0);

    idle();
    wr(0, 6, 1, 'hBEEF); cyc(1);
    idle(); init_req = 1; cyc(1);
    init_req = 0;
    chk("reinit_low", 32'(ready), 32'd0);
    cyc(7);
    chk("reinit_low_8", 32'(ready), 32'd0);
    rd(0, 6, 1);
    cyc(1);
    chk("reinit_up", 32'(ready), 32'd1);
    cyc(1);
    chk("reinit_ctx6_b1", 32'(rd_cost[15:0]), 32'h0110);

    idle(); init_req = 1; cyc(1);
    init_req = 0; cyc(4);
    rst = 1; cyc(1);
    rst = 0; cyc(7);
    chk("rst_mid_low", 32'(ready), 32'd0);
    cyc(1);
    chk("rst_mid_up", 32'(ready), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      idle();
      rst      = ($urandom_range(0, 799) == 0);
      init_req = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 1) begin
        int d;
        case ($urandom_range(0, 5))
          0: d = 'hFFFF;
          1: d = 'h8000;
          2: d = 'h7FFF;
          3: d = $urandom_range(0, 'h40);
          default: d = $urandom_range(0, 'hFFFF);
        endcase
        wr($urandom_range(0, 1), ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255)
                                                              : $urandom_range(0, 8),
           $urandom_range(0, 1), d);
      end
      for (int k = 0; k < NUM_RD; k++)
        rd(k, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7),
           $urandom_range(0, 1));
      cyc(1);
    end

    idle();
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/context_cost_table.md
Name: context_cost_table

Overview:
- Parametrised successor to the single-read context bit-cost register file in the CABAC rate estimator.
- Holds per-context, per-bin bit costs and serves NUM_RD independent registered read channels.
- Supports overwrite or saturating-accumulate writes, and self-initialises from a per-context-type init table via an internal sequencer.
- Triggered after reset and on demand, e.g. at slice start.

Parameters:
NUM_CTX, 8, number of contexts held (1..256)
CTX_TYPE, 0, selects the init table set in the package
COST_W, 16, bit-cost width (unsigned, fractional-bit units)
NUM_RD, 2, number of independent read channels
ADDR_W, 8, context address width on write and read ports

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
init_req  in  1  one-cycle request to re-initialise all contexts
ready  out  1  table initialised; writes accepted, reads valid
wr_en  in  1  write strobe
wr_mode  in  1  0 = overwrite, 1 = saturating accumulate
wr_ctx  in  ADDR_W  write context index
wr_bin  in  1  bin selected for write
wr_data  in  COST_W  overwrite value, or two's-complement delta in accumulate mode
wr_drop  out  1  pulse: previous-cycle write was ignored
rd_ctx  in  NUM_RD*ADDR_W  per-channel read context (channel k at [k*ADDR_W +: ADDR_W])
rd_bin  in  NUM_RD  per-channel bin select
rd_cost  out  NUM_RD*COST_W  per-channel cost of the selected bin
rd_cost0  out  NUM_RD*COST_W  per-channel bin0 cost
rd_cost1  out  NUM_RD*COST_W  per-channel bin1 cost

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: ready=0, wr_drop=0, all rd_* outputs 0.
- After reset the FSM is in INIT with idx=0. Array contents are don't-care until written.
- FSM state INIT:
  - Each cycle writes both bins of context idx from context_cost_init_rom, then idx++.
  - After writing idx=NUM_CTX-1, moves to READY.
  - ready rises exactly NUM_CTX cycles after the first clk edge with rst low.
- FSM state READY:
  - init_req=1 moves to INIT with idx=0; ready is low from the next cycle.
  - init_req in INIT restarts from idx=0.
  - rst mid-INIT restarts from idx=0.
- Write acceptance: a write is accepted only if ready=1 and wr_ctx<NUM_CTX.
  - Any other wr_en=1 is dropped: no array change, and wr_drop=1 on the following cycle only.
- Overwrite (wr_mode=0): cost[wr_ctx][wr_bin] <= wr_data.
- Accumulate (wr_mode=1):
  - Computes cost + signed(wr_data) at COST_W+2 bits.
  - Clamps the result to [0, 2^COST_W-1] and writes it.
  - Only the addressed bin changes; the other bin of the same context is untouched.
- Reads, per channel k:
  - 1-cycle latency: values sampled at edge t appear after edge t.
  - rd_cost = rd_bin ? bin1 : bin0; rd_cost0 and rd_cost1 always show both bins.
  - All channels are independent; any channels may address the same context.
- Read output zeroing:
  - If ready=0 or rd_ctx>=NUM_CTX, all three outputs for that channel register 0.
  - A read issued in the cycle ready first rises returns the table value.
- Write-to-read bypass: a read in the same cycle as an accepted write to the same ctx returns the post-write (including saturated) value on the next cycle. This holds on all channels.
- One write port only; no write collisions are possible.

Decomposition:
- Package cabac_rate_pkg holds:
  - cost_t typedef (COST_W bits);
  - state enum {INIT, READY};
  - constant table CTX_INIT_COST[type][ctx][bin];
  - function sat_add_cost(cost, delta) implementing the clamp.
- Sub-module context_cost_init_rom (combinational):
  - inputs: CTX_TYPE parameter and idx;
  - outputs: init0 and init1 from the package table.
- Top module holds the array, FSM and counter, write datapath, bypass, and the NUM_RD generate loop.

Test Plan:
(NUM_CTX=8, NUM_RD=2, COST_W=16 throughout.)
- Reset and init:
  - Stimulus: rst high 2 cycles, then release.
  - Response: ready=0 for 8 cycles, then 1.
  - Then read ch0 ctx=2 bin=1 and ch1 ctx=7 bin=0 → CTX_INIT_COST[0][2][1] and CTX_INIT_COST[0][7][0] one cycle later.
- Dropped writes:
  - Stimulus: wr ctx=1 data=1111 during init; later wr ctx=100 data=DEAD.
  - Response: wr_drop=1 the cycle after each; ctx0..7 unchanged.
  - Also: rd ctx=31 → rd_cost/rd_cost0/rd_cost1 = 0.
- Back-to-back writes and bin isolation:
  - Stimulus: wr ctx1 bin0=1111, then ctx1 bin1=2222; then wr ctx4 bin0=AAAA.
  - Response: ch0 ctx1 bin0 → 1111; ch1 ctx1 bin1 → 2222, both in the same cycle.
  - ctx4 rd_cost0=AAAA; rd_cost1 = init value.
- Bypass:
  - Stimulus: wr ctx5 bin1=FACE with ch0 and ch1 both reading ctx5 bin1 in the same cycle.
  - Response: both channels show FACE on the next cycle.
- Saturating accumulate on ctx3 bin0:
  - Overwrite FFF0, then acc +0020 → FFFF.
  - Overwrite 0100, then acc delta 8000 (−32768) → 0000.
  - bin1 stays at its init value throughout.
- Re-init and reset mid-op:
  - Stimulus: wr ctx6 bin1=BEEF, then init_req.
  - Response: ready low 8 cycles, then ctx6 bin1 = CTX_INIT_COST[0][6][1].
  - Also: rst asserted at idx=4 of init restarts it, and ready comes 8 cycles after release.
